// File: rtl/mux8_4to1b.sv
// -----------------------------------------------------------------------------
// mux8_4to1b -- 4-input byte steering multiplexer with optional registered copy
//
// Selects one of four WIDTH-bit sources onto F using a one-hot 2-to-4 select
// decode and per-bit AND-OR gating (no priority between sources). F is purely
// combinational. F_q is a load-enabled register of F for pipelined consumers.
//
// Ports (positional order is fixed; legacy users connect only the first six):
//   F      out  WIDTH  combinational selected data
//   A      in   WIDTH  source, Sel=2'b00
//   B      in   WIDTH  source, Sel=2'b01
//   C      in   WIDTH  source, Sel=2'b10
//   D      in   WIDTH  source, Sel=2'b11
//   Sel    in   2      select
//   clk    in   1      rising-edge clock, F_q only
//   rst_n  in   1      async active-low reset, F_q only
//   en     in   1      load enable for F_q
//   F_q    out  WIDTH  registered copy of F
// -----------------------------------------------------------------------------

// One output bit: AND each source with its decoded select, then OR.
module mux8_4to1b_lane (
    input  wire i_a,
    input  wire i_b,
    input  wire i_c,
    input  wire i_d,
    input  wire i_s0,
    input  wire i_s1,
    input  wire i_s2,
    input  wire i_s3,
    output wire o_f
);
    wire w_t0, w_t1, w_t2, w_t3;

    and g_a0 (w_t0, i_a, i_s0);
    and g_a1 (w_t1, i_b, i_s1);
    and g_a2 (w_t2, i_c, i_s2);
    and g_a3 (w_t3, i_d, i_s3);
    or  g_o  (o_f, w_t0, w_t1, w_t2, w_t3);
endmodule

module mux8_4to1b #(
    parameter int WIDTH = 8
) (
    output logic [WIDTH-1:0] F,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    input  logic [WIDTH-1:0] D,
    input  logic [1:0]       Sel,
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] F_q
);
    logic             w_s0, w_s1, w_s2, w_s3;
    logic [WIDTH-1:0] w_f;
    logic [WIDTH-1:0] r_fq;

    // One-hot decode; exactly one term is high for any known Sel.
    assign w_s0 = ~Sel[1] & ~Sel[0];
    assign w_s1 = ~Sel[1] &  Sel[0];
    assign w_s2 =  Sel[1] & ~Sel[0];
    assign w_s3 =  Sel[1] &  Sel[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mux8_4to1b_lane u_lane (
            .i_a  (A[i]),
            .i_b  (B[i]),
            .i_c  (C[i]),
            .i_d  (D[i]),
            .i_s0 (w_s0),
            .i_s1 (w_s1),
            .i_s2 (w_s2),
            .i_s3 (w_s3),
            .o_f  (w_f[i])
        );
    end

    // F never touches clk/rst_n/en, so it stays correct when those are left open.
    assign F = w_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_fq <= '0;
        else if (en)
            r_fq <= w_f;
    end

    assign F_q = r_fq;
endmodule

// File: tb/tb_mux8_4to1b.sv
module tb_mux8_4to1b;
    logic [7:0] A, B, C, D, F, F_q;
    logic [1:0] Sel;
    logic       clk, rst_n, en;

    mux8_4to1b #(.WIDTH(8)) dut (
        .F(F), .A(A), .B(B), .C(C), .D(D), .Sel(Sel),
        .clk(clk), .rst_n(rst_n), .en(en), .F_q(F_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] f;
        logic [7:0] fq;
        bit         chk_fq;
    } exp_t;

    exp_t sb_q[$];
    event ev_chk;
    int   checks = 0;
    int   errors = 0;

    // Monitor: pops one expectation per strobe and compares against the DUT.
    always @(ev_chk) begin
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty: strobe with no expectation");
        end else begin
            e = sb_q.pop_front();
            checks++;
            if (F !== e.f) begin
                errors++;
                $display("FAIL %s F: got %h want %h", e.name, F, e.f);
            end
            if (e.chk_fq) begin
                checks++;
                if (F_q !== e.fq) begin
                    errors++;
                    $display("FAIL %s F_q: got %h want %h", e.name, F_q, e.fq);
                end
            end
        end
    end

    // Settle inputs, queue the expectation, then let the monitor sample.
    task automatic expect_out(input string name, input logic [7:0] f,
                              input logic [7:0] fq, input bit chk_fq);
        exp_t e;
        #1;
        e.name = name; e.f = f; e.fq = fq; e.chk_fq = chk_fq;
        sb_q.push_back(e);
        -> ev_chk;
        #1;
    endtask

    function automatic logic [7:0] ref_mux(input logic [7:0] a, b, c, d,
                                           input logic [1:0] s);
        case (s)
            2'b00:   return a;
            2'b01:   return b;
            2'b10:   return c;
            default: return d;
        endcase
    endfunction

    initial begin
        logic [7:0] m_fq;
        logic [7:0] exp_f;
        int         wait_cnt;

        rst_n = 1'b0; en = 1'b0;
        A = 8'hAA; B = 8'h55; C = 8'hF0; D = 8'h0F; Sel = 2'b00;
        expect_out("reset_state", 8'hAA, 8'h00, 1'b1);

        // Static sweep, register held in reset and disabled.
        @(negedge clk); Sel = 2'b00; expect_out("sweep_00", 8'hAA, 8'h00, 1'b1);
        @(negedge clk); Sel = 2'b01; expect_out("sweep_01", 8'h55, 8'h00, 1'b1);
        @(negedge clk); Sel = 2'b10; expect_out("sweep_10", 8'hF0, 8'h00, 1'b1);
        @(negedge clk); Sel = 2'b11; expect_out("sweep_11", 8'h0F, 8'h00, 1'b1);

        // Data change under fixed select.
        @(negedge clk); Sel = 2'b10; C = 8'h3C;
        expect_out("data_c_follow", 8'h3C, 8'h00, 1'b0);
        A = 8'h12; B = 8'h34; D = 8'h56;
        expect_out("data_other_ignored", 8'h3C, 8'h00, 1'b0);
        A = 8'hAA; B = 8'h55; C = 8'hF0; D = 8'h0F;

        // Reset dominates en across a clock edge.
        en = 1'b1; Sel = 2'b11;
        @(negedge clk); expect_out("reset_overrides_en", 8'h0F, 8'h00, 1'b1);

        // Release reset, then load D.
        rst_n = 1'b1;
        @(negedge clk); expect_out("load_d", 8'h0F, 8'h0F, 1'b1);

        // Hold with en=0.
        en = 1'b0; Sel = 2'b00;
        expect_out("hold_pre", 8'hAA, 8'h0F, 1'b1);
        @(negedge clk); expect_out("hold_after_edge", 8'hAA, 8'h0F, 1'b1);

        // Mid-operation async reset between edges.
        Sel = 2'b01; rst_n = 1'b0;
        expect_out("async_reset", 8'h55, 8'h00, 1'b1);

        // Release and reload from B.
        @(negedge clk); rst_n = 1'b1; en = 1'b1; Sel = 2'b01; B = 8'h55;
        expect_out("post_reset_pre", 8'h55, 8'h00, 1'b1);
        @(negedge clk); expect_out("post_reset_load", 8'h55, 8'h55, 1'b1);

        // Random vectors; m_fq models the register from the previous edge.
        m_fq = 8'h55;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            A = 8'($urandom); B = 8'($urandom); C = 8'($urandom); D = 8'($urandom);
            Sel = 2'(i % 4);
            en  = 1'($urandom_range(0, 1));
            exp_f = ref_mux(A, B, C, D, Sel);
            expect_out("random", exp_f, m_fq, 1'b1);
            if (en) m_fq = exp_f;
        end

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 100) begin
            #1; wait_cnt++;
        end
        if (sb_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
